// File: rtl/display_scan_pkg.sv
// ============================================================================
//  Module      : display_scan_pkg
//  Description : Segment codes, scan-state encodings and hex decode helper
//                shared by the display scanner and its segment decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_scan_pkg;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_R     = 7'h2F;

    localparam logic [0:0] ST_SHOW  = 1'b0;
    localparam logic [0:0] ST_BLANK = 1'b1;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0:    code = SEG_0;
            4'h1:    code = SEG_1;
            4'h2:    code = SEG_2;
            4'h3:    code = SEG_3;
            4'h4:    code = SEG_4;
            4'h5:    code = SEG_5;
            4'h6:    code = SEG_6;
            4'h7:    code = SEG_7;
            4'h8:    code = SEG_8;
            4'h9:    code = SEG_9;
            4'hA:    code = SEG_A;
            4'hB:    code = SEG_B;
            4'hC:    code = SEG_C;
            4'hD:    code = SEG_D;
            4'hE:    code = SEG_E;
            default: code = SEG_F;
        endcase
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/display_seg_decoder.sv
// ============================================================================
//  Module      : display_seg_decoder
//  Description : Combinational nibble/err/digit/blank to active-low 7-segment
//                code; Err mode spells "Err " across digits 3..0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_seg_decoder
    import display_scan_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_err,
    input  logic [1:0] i_digit,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        // Err text takes priority over any blanking request
        if (i_err) begin
            case (i_digit)
                2'd3:       o_seg = SEG_E;
                2'd2, 2'd1: o_seg = SEG_R;
                default:    o_seg = SEG_BLANK;
            endcase
        end else if (!i_blank) begin
            o_seg = hex_to_seg(i_nibble);
        end
    end

endmodule

`default_nettype wire

// File: rtl/display_scan.sv
// ============================================================================
//  Module      : display_scan
//  Description : Four-digit multiplexed common-anode 7-segment driver with
//                blanking gap between digits. Optional leading-zero blanking
//                when DISPLAY_SCAN_LZB_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scan
    import display_scan_pkg::*;
#(
    parameter int DIV_W     = 16,
    parameter int BLANK_CYC = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] DATAH,
    input  logic [7:0] DATAL,
    input  logic       LOAD,
    input  logic       ERR,
    output logic [3:0] AN,
    output logic [6:0] SEG,
    output logic       DP,
    output logic       BUSY
);

    localparam int                   c_blk_w    = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [c_blk_w-1:0]   c_blk_last = c_blk_w'(BLANK_CYC - 1);
    localparam logic [c_blk_w-1:0]   c_blk_one  = c_blk_w'(1);
    localparam logic [DIV_W-1:0]     c_pre_max  = {DIV_W{1'b1}};
    localparam logic [DIV_W-1:0]     c_pre_one  = DIV_W'(1);

    logic [15:0]        r_data;
    logic               r_err;
    logic [1:0]         r_idx;
    logic [DIV_W-1:0]   r_pre;
    logic [c_blk_w-1:0] r_blk;
    logic [0:0]         r_state;

    logic [3:0]         w_nibble;
    logic               w_lzb;
    logic [6:0]         w_seg;

    assign w_nibble = r_data[{r_idx, 2'b00} +: 4];

`ifdef DISPLAY_SCAN_LZB_EN
    // A digit is a leading zero when it and every higher digit are zero
    always_comb begin
        case (r_idx)
            2'd3:    w_lzb = (r_data[15:12] == 4'h0);
            2'd2:    w_lzb = (r_data[15:8]  == 8'h00);
            2'd1:    w_lzb = (r_data[15:4]  == 12'h000);
            default: w_lzb = 1'b0;
        endcase
    end
`else
    assign w_lzb = 1'b0;
`endif

    display_seg_decoder u_dec (
        .i_nibble (w_nibble),
        .i_err    (r_err),
        .i_digit  (r_idx),
        .i_blank  (w_lzb),
        .o_seg    (w_seg)
    );

    assign DP = 1'b1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_data  <= 16'h0000;
            r_err   <= 1'b0;
            r_idx   <= 2'd0;
            r_pre   <= '0;
            r_blk   <= '0;
            r_state <= ST_SHOW;
            AN      <= 4'b1111;
            SEG     <= SEG_BLANK;
            BUSY    <= 1'b0;
        end else begin
            // Capture is independent of the scan so timing never slips
            if (LOAD) begin
                r_data <= {DATAH, DATAL};
                r_err  <= ERR;
            end
            if (r_state == ST_SHOW) begin
                AN   <= ~(4'b0001 << r_idx);
                SEG  <= w_seg;
                BUSY <= 1'b0;
                if (r_pre == c_pre_max) begin
                    r_pre   <= '0;
                    r_state <= ST_BLANK;
                end else begin
                    r_pre <= r_pre + c_pre_one;
                end
            end else begin
                AN   <= 4'b1111;
                SEG  <= SEG_BLANK;
                BUSY <= 1'b1;
                if (r_blk == c_blk_last) begin
                    r_blk   <= '0;
                    r_idx   <= r_idx + 2'd1;
                    r_state <= ST_SHOW;
                end else begin
                    r_blk <= r_blk + c_blk_one;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_display_scan.sv
// ============================================================================
//  Module      : tb_display_scan
//  Description : Directed scoreboard bench for display_scan (DIV_W=3,
//                BLANK_CYC=2); honours DISPLAY_SCAN_LZB_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_scan;

    localparam int SHOW_CYC = 8;
    localparam int SLOT_CYC = 10;

    logic       CLK;
    logic       RESET;
    logic [7:0] DATAH;
    logic [7:0] DATAL;
    logic       LOAD;
    logic       ERR;
    logic [3:0] AN;
    logic [6:0] SEG;
    logic       DP;
    logic       BUSY;

    display_scan #(.DIV_W(3), .BLANK_CYC(2)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .DATAH (DATAH),
        .DATAL (DATAL),
        .LOAD  (LOAD),
        .ERR   (ERR),
        .AN    (AN),
        .SEG   (SEG),
        .DP    (DP),
        .BUSY  (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int           vectors = 0;
    int           miscompares = 0;
    int           k = 0;
    int           last_p = -1;
    int           last_dg = -1;
    logic [15:0]  m_data = 16'h0000;
    logic         m_err = 1'b0;
    logic [6:0]   hex_tab [16];
    logic [12:0]  sbq [$];
    localparam logic [12:0] RST_VEC = {4'b1111, 7'h7F, 1'b1, 1'b0};

    function automatic logic [6:0] exp_seg(input logic [15:0] d, input logic e, input int dg);
        logic [3:0] nib;
        nib = d[dg*4 +: 4];
        if (e) begin
            if (dg == 3) return 7'h06;
            if (dg == 0) return 7'h7F;
            return 7'h2F;
        end
`ifdef DISPLAY_SCAN_LZB_EN
        if (dg > 0 && (d >> (4 * dg)) == 16'h0000) return 7'h7F;
`endif
        return hex_tab[nib];
    endfunction

    task automatic compare(input string tag);
        logic [12:0] e;
        logic [12:0] obs;
        e = sbq.pop_front();
        obs = {AN, SEG, DP, BUSY};
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s k=%0d: observed AN/SEG/DP/BUSY=%h expected %h", tag, k, obs, e);
        end
    endtask

    task automatic tick(input string tag);
        logic [3:0] an_e;
        int p;
        int dg;
        @(posedge CLK);
        k++;
        p  = (k - 1) % SLOT_CYC;
        dg = ((k - 1) / SLOT_CYC) % 4;
        if (p < SHOW_CYC) begin
            an_e = 4'b1111;
            an_e[dg] = 1'b0;
            sbq.push_back({an_e, exp_seg(m_data, m_err, dg), 1'b1, 1'b0});
        end else begin
            sbq.push_back({4'b1111, 7'h7F, 1'b1, 1'b1});
        end
        last_p  = p;
        last_dg = dg;
        if (LOAD) begin
            m_data = {DATAH, DATAL};
            m_err  = ERR;
        end
        #1;
        compare(tag);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic load(input logic [15:0] v, input logic e, input string tag);
        DATAH = v[15:8];
        DATAL = v[7:0];
        ERR   = e;
        LOAD  = 1'b1;
        tick(tag);
        LOAD  = 1'b0;
    endtask

    initial begin
        int n;
        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        RESET = 1'b1;
        LOAD  = 1'b0;
        ERR   = 1'b0;
        DATAH = 8'h00;
        DATAL = 8'h00;

        // reset values, then idle scan of 0000
        #22;
        sbq.push_back(RST_VEC);
        compare("reset_hold");
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        sbq.push_back(RST_VEC);
        compare("reset_release");
        ticks(30, "idle_scan");

        // value 0x12AF over a full rotation
        load(16'h12AF, 1'b0, "load_12af");
        ticks(45, "scan_12af");

        // Err mode, then back to zero
        load(16'h1234, 1'b1, "load_err");
        ticks(42, "scan_err");
        load(16'h0000, 1'b0, "load_zero");
        ticks(42, "scan_zero");

        // capture during the blanking gap
        n = 0;
        while (last_p != SHOW_CYC && n < 20) begin
            tick("seek_blank");
            n++;
        end
        vectors++;
        assert (last_p == SHOW_CYC) else begin
            miscompares++;
            $error("FAIL seek_blank: observed slot pos %0d expected %0d", last_p, SHOW_CYC);
        end
        load(16'h5555, 1'b0, "load_in_blank");
        ticks(12, "scan_5555");

        // asynchronous reset mid-show on digit 2
        n = 0;
        while (!(last_dg == 2 && last_p == 3) && n < 60) begin
            tick("seek_digit2");
            n++;
        end
        vectors++;
        assert (last_dg == 2 && last_p == 3) else begin
            miscompares++;
            $error("FAIL seek_digit2: observed digit %0d pos %0d expected digit 2 pos 3", last_dg, last_p);
        end
        #2;
        RESET = 1'b1;
        #1;
        sbq.push_back(RST_VEC);
        compare("async_reset");
        @(negedge CLK);
        RESET  = 1'b0;
        k      = 0;
        m_data = 16'h0000;
        m_err  = 1'b0;
        #1;
        sbq.push_back(RST_VEC);
        compare("after_reset");
        ticks(12, "restart_scan");

        // leading-zero candidate value
        load(16'h00A0, 1'b0, "load_00a0");
        ticks(42, "scan_00a0");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
